// File: rtl/isqrt_seq_if.sv
// Valid/ready bus for the sequential integer square-root unit.
// master = radicand producer / result consumer; slave = the root unit.
interface isqrt_seq_if #(
  parameter int unsigned W = 6
);
  localparam int unsigned HW = W / 2;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_x;
  logic          out_valid;
  logic          out_ready;
  logic [HW-1:0] out_root;
  logic [HW:0]   out_rem;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_root, out_rem
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_root, out_rem
  );
endinterface

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root: one root bit per clock,
// returns floor(sqrt(x)) and x - root^2 over a valid/ready bus.
module isqrt_seq #(
  parameter int unsigned W = 6
) (
  input logic        clk,
  input logic        rst_n,
  isqrt_seq_if.slave bus
);
  localparam int unsigned HW = W / 2;
  localparam int unsigned RW = HW + 2;
  localparam int unsigned CW = (HW > 1) ? $clog2(HW) : 1;

  if ((W < 2) || ((W % 2) != 0)) begin : g_bad_w
    $error("isqrt_seq: W must be even and >= 2");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [HW-1:0] root_q, root_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] out_root_q, out_root_d;
  logic [HW:0]   out_rem_q, out_rem_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [RW-1:0] rem_t;
  logic [RW-1:0] trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      out_root_q  <= '0;
      out_rem_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      out_root_q  <= out_root_d;
      out_rem_q   <= out_rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    rem_d      = rem_q;
    root_d     = root_q;
    cnt_d      = cnt_q;
    out_root_d = out_root_q;
    out_rem_d  = out_rem_q;
    // Partial remainder never exceeds 2*root, so its top two bits are free to drop.
    rem_t      = {rem_q[RW-3:0], x_q[W-1:W-2]};
    trial      = {root_q, 2'b01};

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          x_d     = bus.in_x;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(HW - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        x_d = x_q << 2;
        if (rem_t >= trial) begin
          rem_d  = rem_t - trial;
          root_d = HW'({root_q, 1'b1});
        end else begin
          rem_d  = rem_t;
          root_d = HW'({root_q, 1'b0});
        end
        if (cnt_q == '0) begin
          out_root_d = root_d;
          out_rem_d  = rem_d[RW-2:0];
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_root  = out_root_q;
  assign bus.out_rem   = out_rem_q;
endmodule
